// File: rtl/led_multi_ctrl.sv
// Multi-channel LED driver: shared tick prescaler and PWM counter, one
// led_ch instance per channel holding mode/half/duty and its own timer.

// One LED channel: config registers, blink/activity timer, PWM gating.
module led_ch #(
    parameter int PERIOD_W = 16,
    parameter int PWM_W    = 8,
    parameter int DEF_HALF = 250
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                act,
    input  logic                wr,
    input  logic [1:0]          wr_mode,
    input  logic [PERIOD_W-1:0] wr_half,
    input  logic [PWM_W-1:0]    wr_duty,
    input  logic [PWM_W-1:0]    pwm_cnt,
    output logic                led
);
    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_ACT   = 2'd3
    } mode_e;

    mode_e               mode_q, mode_d;
    logic [PERIOD_W-1:0] half_q, half_d;
    logic [PWM_W-1:0]    duty_q, duty_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                phase_q, phase_d;
    logic                led_q, led_d;
    logic [PERIOD_W-1:0] last_cnt;
    logic                base;
    logic                pwm_en;

    // Next-state: a write wins over tick/act and restarts the timer.
    always_comb begin
        mode_d   = mode_q;
        half_d   = half_q;
        duty_d   = duty_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        // half=0 behaves as half=1, so the terminal count is never negative.
        last_cnt = (half_q == '0) ? '0 : half_q - PERIOD_W'(1);
        if (wr) begin
            mode_d  = mode_e'(wr_mode);
            half_d  = wr_half;
            duty_d  = wr_duty;
            cnt_d   = '0;
            phase_d = 1'b0;
        end else begin
            case (mode_q)
                MODE_BLINK: begin
                    if (tick) begin
                        if (cnt_q >= last_cnt) begin
                            cnt_d   = '0;
                            phase_d = ~phase_q;
                        end else begin
                            cnt_d = cnt_q + PERIOD_W'(1);
                        end
                    end
                end
                MODE_ACT: begin
                    // Retriggerable: a new pulse reloads the full stretch.
                    if (act)
                        cnt_d = half_q;
                    else if (tick && cnt_q != '0)
                        cnt_d = cnt_q - PERIOD_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Base level from mode, then gated by the PWM comparator.
    always_comb begin
        case (mode_q)
            MODE_ON:    base = 1'b1;
            MODE_BLINK: base = phase_q;
            MODE_ACT:   base = (cnt_q != '0);
            default:    base = 1'b0;
        endcase
        pwm_en = (&duty_q) | (pwm_cnt < duty_q);
        led_d  = base & pwm_en;
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= MODE_OFF;
            half_q  <= PERIOD_W'(DEF_HALF);
            duty_q  <= '1;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            half_q  <= half_d;
            duty_q  <= duty_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            led_q   <= led_d;
        end
    end

    assign led = led_q;
endmodule

module led_multi_ctrl #(
    parameter int NUM_CH   = 4,
    parameter int TICK_DIV = 50000,
    parameter int PERIOD_W = 16,
    parameter int PWM_W    = 8,
    parameter int DEF_HALF = 250,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_wr,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [PERIOD_W-1:0] cfg_half,
    input  logic [PWM_W-1:0]    cfg_duty,
    input  logic [NUM_CH-1:0]   act,
    output logic                tick_o,
    output logic [NUM_CH-1:0]   led
);
    localparam int PRE_W = $clog2(TICK_DIV);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [PWM_W-1:0] pwm_q, pwm_d;
    logic             tick;

    assign tick   = (pre_q == PRE_W'(TICK_DIV - 1));
    assign tick_o = tick;

    // Prescaler wraps at TICK_DIV-1; PWM counter free-runs.
    always_comb begin
        pre_d = tick ? '0 : pre_q + PRE_W'(1);
        pwm_d = pwm_q + PWM_W'(1);
    end

    // Shared time-base registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
            pwm_q <= '0;
        end else begin
            pre_q <= pre_d;
            pwm_q <= pwm_d;
        end
    end

    // Out-of-range cfg_ch matches no instance, so such writes are dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        led_ch #(
            .PERIOD_W (PERIOD_W),
            .PWM_W    (PWM_W),
            .DEF_HALF (DEF_HALF)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .tick    (tick),
            .act     (act[i]),
            .wr      (cfg_wr && (cfg_ch == CH_W'(i))),
            .wr_mode (cfg_mode),
            .wr_half (cfg_half),
            .wr_duty (cfg_duty),
            .pwm_cnt (pwm_q),
            .led     (led[i])
        );
    end
endmodule

// File: tb/tb_led_multi_ctrl.sv
// Bench for led_multi_ctrl: tick-count reference model compared every
// cycle, plus directed literal checks of blink, dimming, activity, reset.
module tb_led_multi_ctrl;
    localparam int NCH = 4;
    localparam int TDIV = 4;
    localparam int PW = 8;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_wr = 1'b0;
    logic [1:0]    cfg_ch = '0;
    logic [1:0]    cfg_mode = '0;
    logic [PW-1:0] cfg_half = '0;
    logic [DW-1:0] cfg_duty = '0;
    logic [NCH-1:0] act = '0;
    logic          tick_o;
    logic [NCH-1:0] led;

    int n_chk = 0;
    int n_fail = 0;

    led_multi_ctrl #(
        .NUM_CH(NCH), .TICK_DIV(TDIV), .PERIOD_W(PW), .PWM_W(DW), .DEF_HALF(250)
    ) dut (
        .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_half(cfg_half), .cfg_duty(cfg_duty),
        .act(act), .tick_o(tick_o), .led(led)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_chk++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_rng(input string name, input int actual, input int lo, input int hi);
        n_chk++;
        if (actual < lo || actual > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, actual, lo, hi, $time);
        end
    endtask

    // Reference model: time is counted in clocks (cyc) and ticks (T) since
    // reset; blink phase and activity stretch are derived from how many
    // ticks elapsed since the last write / last activity load.
    int m_mode[NCH], m_half[NCH], m_duty[NCH];
    int m_wr_t[NCH], m_ld_t[NCH];
    bit m_ld[NCH];
    int cyc, tcnt;
    logic [NCH-1:0] exp_led;

    function automatic bit m_base(input int i);
        int h;
        case (m_mode[i])
            1: return 1'b1;
            2: begin
                h = (m_half[i] < 1) ? 1 : m_half[i];
                return 1'(((tcnt - m_wr_t[i]) / h) % 2);
            end
            3: return m_ld[i] && ((tcnt - m_ld_t[i]) < m_half[i]);
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_mode[i] = 0; m_half[i] = 250; m_duty[i] = 15;
                m_wr_t[i] = 0; m_ld_t[i] = 0; m_ld[i] = 0;
            end
            cyc = 0; tcnt = 0; exp_led = '0;
        end else begin
            logic [NCH-1:0] nl;
            for (int i = 0; i < NCH; i++)
                nl[i] = m_base(i) && (m_duty[i] == 15 || (cyc % 16) < m_duty[i]);
            if (cyc % TDIV == TDIV - 1) tcnt++;
            for (int i = 0; i < NCH; i++) begin
                if (cfg_wr && int'(cfg_ch) == i) begin
                    m_mode[i] = int'(cfg_mode); m_half[i] = int'(cfg_half);
                    m_duty[i] = int'(cfg_duty); m_wr_t[i] = tcnt; m_ld[i] = 0;
                end else if (m_mode[i] == 3 && act[i]) begin
                    m_ld[i] = 1; m_ld_t[i] = tcnt;
                end
            end
            exp_led = nl;
            cyc++;
        end
    end

    // Compare DUT against the model on every non-reset cycle.
    always @(negedge clk) begin
        if (!rst) begin
            check("led_vs_model", int'(led), int'(exp_led));
            check("tick_vs_model", int'(tick_o), int'(cyc % TDIV == TDIV - 1));
        end
    end

    task automatic wr(input int ch, input int mode, input int half, input int duty);
        @(negedge clk);
        cfg_wr = 1'b1; cfg_ch = 2'(ch); cfg_mode = 2'(mode);
        cfg_half = PW'(half); cfg_duty = DW'(duty);
        @(negedge clk);
        cfg_wr = 1'b0;
    endtask

    // Count cycles (sampled at negedge) where led[ch] is high.
    task automatic ones(input int ch, input int n, output int cnt, output int max_run);
        int run;
        cnt = 0; max_run = 0; run = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (led[ch]) begin
                cnt++; run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
        end
    endtask

    initial begin
        int c, r, t;
        bit seen;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_led", int'(led), 0);
        check("reset_tick", int'(tick_o), 0);
        #2 rst = 1'b0;

        // Idle: dark, tick every 4 clocks.
        c = 0; t = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (led != '0) c++;
            if (tick_o) t++;
        end
        check("idle_dark", c, 0);
        check("idle_ticks", t, 10);

        // Blink ch1 half=3: 12 low / 12 high.
        wr(1, 2, 3, 15);
        repeat (30) @(negedge clk);
        ones(1, 48, c, r);
        check("blink_ones", c, 24);
        check("blink_run", r, 12);

        // Dimming on ch0.
        wr(0, 1, 0, 4);
        repeat (2) @(negedge clk);
        ones(0, 16, c, r);
        check("duty4_ones", c, 4);
        wr(0, 1, 0, 0);
        repeat (2) @(negedge clk);
        ones(0, 16, c, r);
        check("duty0_ones", c, 0);
        wr(0, 1, 0, 15);
        repeat (2) @(negedge clk);
        ones(0, 16, c, r);
        check("dutyF_ones", c, 16);

        // Activity stretch on ch2.
        wr(2, 3, 2, 15);
        repeat (3) @(negedge clk);
        act[2] = 1'b1; @(negedge clk); act[2] = 1'b0;
        ones(2, 20, c, r);
        check_rng("act_single", c, 5, 8);
        check("act_expired", int'(led[2]), 0);
        act[2] = 1'b1; @(negedge clk); act[2] = 1'b0;
        repeat (4) @(negedge clk);
        act[2] = 1'b1; @(negedge clk); act[2] = 1'b0;
        ones(2, 24, c, r);
        check_rng("act_retrig", c, 8, 12);

        // Write coincident with tick and act on ch3.
        seen = 0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            if (tick_o) seen = 1;
        end
        check("tick_seen", int'(seen), 1);
        cfg_wr = 1'b1; cfg_ch = 2'd3; cfg_mode = 2'd3; cfg_half = 8'd2; cfg_duty = 4'hF;
        act[3] = 1'b1;
        @(negedge clk);
        cfg_wr = 1'b0; act[3] = 1'b0;
        ones(3, 12, c, r);
        check("wr_beats_act", c, 0);

        // Reset in the middle of a blink high phase.
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (led[1]) seen = 1;
        end
        check("blink_high_seen", int'(seen), 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_led", int'(led), 0);
        check("async_rst_tick", int'(tick_o), 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        c = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (led != '0) c++;
        end
        check("post_rst_dark", c, 0);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            cfg_wr = ($urandom_range(0, 7) == 0);
            cfg_ch = 2'($urandom_range(0, 3));
            cfg_mode = 2'($urandom_range(0, 3));
            cfg_half = PW'($urandom_range(0, 5));
            case ($urandom_range(0, 3))
                0: cfg_duty = 4'h0;
                1: cfg_duty = 4'hF;
                default: cfg_duty = DW'($urandom_range(0, 15));
            endcase
            for (int i = 0; i < NCH; i++) act[i] = ($urandom_range(0, 5) == 0);
        end
        @(negedge clk);
        cfg_wr = 1'b0; act = '0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
